// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 stride-2 signed max pooling over a row pair fed one column per beat.
module max_pool_2x2 #(
  parameter int BIT_WIDTH = 32,
  parameter int IN_WIDTH  = 28,
  parameter int IN_HEIGHT = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [BIT_WIDTH-1:0] in1,
  input  logic signed [BIT_WIDTH-1:0] in2,
  output logic signed [BIT_WIDTH-1:0] out,
  output logic                        out_valid,
  output logic                        frame_done
);
  localparam int PAIRS = IN_HEIGHT / 2;
  localparam int CW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
  localparam int PW = PAIRS > 1 ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IN_WIDTH - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(2 * (IN_WIDTH / 2) - 1);
  localparam logic [PW-1:0] LAST_PAIR = PW'(PAIRS - 1);
  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] pair_q, pair_d;
  logic signed [BIT_WIDTH-1:0] hold_q, hold_d, out_q, out_d, cm;
  logic valid_q, valid_d, done_q, done_d, fire, last;
  // An odd-width trailing column is even-indexed, so it neither loads hold nor fires.
  always_comb begin
    cm      = in1 > in2 ? in1 : in2;
    last    = col_q == LAST_COL;
    fire    = en & col_q[0];
    col_d   = en ? (last ? '0 : col_q + 1'b1) : col_q;
    pair_d  = (en & last) ? (pair_q == LAST_PAIR ? '0 : pair_q + 1'b1) : pair_q;
    hold_d  = (en & ~col_q[0] & ~last) ? cm : hold_q;
    out_d   = fire ? (hold_q > cm ? hold_q : cm) : out_q;
    valid_d = fire;
    done_d  = fire & (col_q == LAST_OUT) & (pair_q == LAST_PAIR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      pair_q  <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      pair_q  <= pair_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  assign out        = out_q;
  assign out_valid  = valid_q;
  assign frame_done = done_q;
endmodule
